// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store initiator with word-boundary split
// Purpose: drives a byte-enabled, word-addressed data memory on behalf of the
// pipeline memory stage. Misaligned accesses that spill into the next word are
// issued as two back-to-back word accesses.
// Ports:
//   clk, reset                  clock (rising edge), async active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   is_store, funct3            access kind and RV32I width/sign code
//   addr, store_data            byte address, right-justified store value
//   resp_valid/resp_err         one-cycle completion pulse, illegal-funct3 flag
//   load_data                   registered, extended load result
//   mem_we/mem_be/mem_a/mem_wd  memory write enable, lanes, word address, data
//   mem_rd                      combinational memory read data
module lsu_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    output logic            resp_valid,
    output logic            resp_err,
    output logic [XLEN-1:0] load_data,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_a,
    output logic [XLEN-1:0] mem_wd,
    input  logic [XLEN-1:0] mem_rd
);

    typedef enum logic {S_IDLE = 1'b0, S_SECOND = 1'b1} state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_load_data;

    // Second-access context captured when a crossing access is accepted
    logic [31:0] r_addr2;
    logic [31:0] r_wd2;
    logic [31:0] r_buf0;
    logic [3:0]  r_be2;
    logic        r_we2;
    logic [1:0]  r_off;
    logic [2:0]  r_f3;

    logic        w_idle;
    logic        w_accept;
    logic        w_legal;
    logic        w_cross;
    logic        w_go;
    logic        w_done;
    logic [3:0]  w_base;
    logic [7:0]  w_m8;
    logic [63:0] w_sd64;
    logic [63:0] w_rd64;
    logic [1:0]  w_off_c;
    logic [2:0]  w_f3_c;
    logic        w_is_load_c;
    logic [31:0] w_raw;
    logic [31:0] w_done_data;

    assign w_idle    = (r_state == S_IDLE);
    assign req_ready = w_idle;
    assign w_accept  = req_valid && w_idle && !reset;

    always_comb begin
        w_legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !is_store;
            default:                w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_base = 4'b1111;
        case (funct3[1:0])
            2'b00:   w_base = 4'b0001;
            2'b01:   w_base = 4'b0011;
            default: w_base = 4'b1111;
        endcase
    end

    // Upper nibble of the shifted mask holds the lanes that fall in the next word
    assign w_m8    = {4'b0000, w_base} << addr[1:0];
    assign w_cross = |w_m8[7:4];
    assign w_sd64  = {32'h0, store_data} << {addr[1:0], 3'b000};
    assign w_go    = w_accept && w_legal;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_go && w_cross) w_next_state = S_SECOND;
            S_SECOND: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // FSM: memory-side outputs
    always_comb begin
        mem_we = 1'b0;
        mem_be = 4'b0000;
        mem_a  = 32'h0;
        mem_wd = 32'h0;
        if (r_state == S_SECOND) begin
            mem_we = r_we2;
            mem_be = r_be2;
            mem_a  = r_addr2;
            mem_wd = r_wd2;
        end else if (w_go) begin
            mem_we = is_store;
            mem_be = w_m8[3:0];
            mem_a  = {addr[31:2], 2'b00};
            mem_wd = w_sd64[31:0];
        end
    end

    // A response is produced on the edge that ends the last (or only) access
    assign w_done = (r_state == S_SECOND) || (w_accept && !(w_legal && w_cross));

    // Non-crossing loads see a zero upper word, so one shifter serves both paths
    assign w_rd64      = (r_state == S_SECOND) ? {mem_rd, r_buf0} : {32'h0, mem_rd};
    assign w_off_c     = (r_state == S_SECOND) ? r_off : addr[1:0];
    assign w_f3_c      = (r_state == S_SECOND) ? r_f3 : funct3;
    assign w_is_load_c = (r_state == S_SECOND) ? !r_we2 : (w_legal && !is_store);
    assign w_raw       = 32'(w_rd64 >> {w_off_c, 3'b000});

    always_comb begin
        w_done_data = 32'h0;
        if (w_is_load_c) begin
            case (w_f3_c)
                3'b000:  w_done_data = {{24{w_raw[7]}}, w_raw[7:0]};
                3'b001:  w_done_data = {{16{w_raw[15]}}, w_raw[15:0]};
                3'b100:  w_done_data = {24'h0, w_raw[7:0]};
                3'b101:  w_done_data = {16'h0, w_raw[15:0]};
                default: w_done_data = w_raw;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_load_data  <= 32'h0;
            r_addr2      <= 32'h0;
            r_wd2        <= 32'h0;
            r_buf0       <= 32'h0;
            r_be2        <= 4'b0000;
            r_we2        <= 1'b0;
            r_off        <= 2'b00;
            r_f3         <= 3'b000;
        end else begin
            r_resp_valid <= w_done;
            r_resp_err   <= w_accept && !w_legal;
            if (w_done) begin
                r_load_data <= w_done_data;
            end
            if (w_go && w_cross) begin
                r_addr2 <= {addr[31:2], 2'b00} + 32'd4;
                r_wd2   <= w_sd64[63:32];
                r_be2   <= w_m8[7:4];
                r_we2   <= is_store;
                r_off   <= addr[1:0];
                r_f3    <= funct3;
                r_buf0  <= mem_rd;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign load_data  = r_load_data;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] load_data;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] tb_mem [16];
    logic        bd_we = 1'b0;
    logic [3:0]  bd_idx = 4'h0;
    logic [31:0] bd_val = 32'h0;
    logic [7:0]  ref_mem [64];

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] g_a2, g_wd2;
    logic [3:0]  g_be2;
    logic        g_rdy2;

    lsu_ctrl #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .is_store(is_store), .funct3(funct3), .addr(addr), .store_data(store_data),
        .resp_valid(resp_valid), .resp_err(resp_err), .load_data(load_data),
        .mem_we(mem_we), .mem_be(mem_be), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = tb_mem[mem_a[5:2]];

    always @(posedge clk) begin
        if (bd_we) begin
            tb_mem[bd_idx] <= bd_val;
        end else if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) tb_mem[mem_a[5:2]][8*i +: 8] <= mem_wd[8*i +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] v);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = idx[3:0]; bd_val = v;
        @(posedge clk);
        #1 bd_we = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[idx*4 + i] = v[8*i +: 8];
    endtask

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
        #1;
    endtask

    task automatic finish_req(input string tag, input int lat_exp, input logic err_exp, input logic [31:0] ld_exp);
        int lat;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        lat = 1;
        g_rdy2 = req_ready; g_a2 = mem_a; g_be2 = mem_be; g_wd2 = mem_wd;
        while (!resp_valid && lat < 4) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check({tag, ".lat"}, lat, lat_exp);
        check({tag, ".err"}, resp_err, err_exp);
        check({tag, ".ld"}, load_data, ld_exp);
        @(negedge clk);
        #1;
        check({tag, ".pulse"}, {resp_valid, resp_err}, 2'b00);
    endtask

    // Byte-level reference: walks the accessed bytes one at a time
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic err,
                         output logic [31:0] ld);
        int          n;
        logic [31:0] v;
        logic [31:0] b;
        logic        legal;
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        err = !legal;
        ld = 32'h0;
        lat = 1;
        if (legal) begin
            n = 1 << f3[1:0];
            if (int'(a[1:0]) + n > 4) lat = 2;
            v = 32'h0;
            for (int i = 0; i < n; i++) begin
                b = a + 32'(i);
                if (st) ref_mem[b[5:0]] = d[8*i +: 8];
                else    v[8*i +: 8] = ref_mem[b[5:0]];
            end
            if (!st) begin
                if (f3 == 3'd0 && v[7])  v[31:8] = '1;
                if (f3 == 3'd1 && v[15]) v[31:16] = '1;
                ld = v;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        err, st;
        logic [2:0]  f3;
        logic [31:0] a, d, ld;
        logic [31:0] bexp [3];

        // Reset state
        @(negedge clk);
        #1;
        check("rst.ready", req_ready, 1'b1);
        check("rst.resp", {resp_valid, resp_err}, 2'b00);
        check("rst.ld", load_data, 32'h0);
        check("rst.be", mem_be, 4'b0000);
        check("rst.a", mem_a, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of a split store
        set_word(0, 32'h11111111);
        set_word(1, 32'h22222222);
        drive(1'b1, 3'b010, 32'h2, 32'hAABBCCDD);
        check("t1.be0", mem_be, 4'b1100);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("t1.second", req_ready, 1'b0);
        reset = 1'b1;
        #1;
        check("t1.ready", req_ready, 1'b1);
        check("t1.resp", resp_valid, 1'b0);
        check("t1.be", mem_be, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t1.w0", tb_mem[0], 32'hCCDD1111);
        check("t1.w1", tb_mem[1], 32'h22222222);
        check("t1.noresp", resp_valid, 1'b0);

        // SB to 0x6
        drive(1'b1, 3'b000, 32'h6, 32'h000000A5);
        check("t2.a", mem_a, 32'h4);
        check("t2.be", mem_be, 4'b0100);
        check("t2.wd", mem_wd, 32'h00A50000);
        check("t2.we", mem_we, 1'b1);
        finish_req("t2", 1, 1'b0, 32'h0);

        // Sub-word loads
        set_word(0, 32'h8899AABB);
        drive(1'b0, 3'b000, 32'h1, 32'h0);
        finish_req("t3.lb", 1, 1'b0, 32'hFFFFFFAA);
        drive(1'b0, 3'b100, 32'h1, 32'h0);
        finish_req("t3.lbu", 1, 1'b0, 32'h000000AA);
        drive(1'b0, 3'b001, 32'h2, 32'h0);
        finish_req("t3.lh", 1, 1'b0, 32'hFFFF8899);

        // Misaligned LW across words
        set_word(0, 32'h44332211);
        set_word(1, 32'h88776655);
        drive(1'b0, 3'b010, 32'h3, 32'h0);
        check("t4.a0", mem_a, 32'h0);
        check("t4.be0", mem_be, 4'b1000);
        finish_req("t4", 2, 1'b0, 32'h77665544);
        check("t4.a1", g_a2, 32'h4);
        check("t4.be1", g_be2, 4'b0111);
        check("t4.rdy1", g_rdy2, 1'b0);

        // SH wrapping past the top of the address space
        set_word(15, 32'h0);
        set_word(0, 32'h0);
        drive(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF);
        check("t5.a0", mem_a, 32'hFFFFFFFC);
        check("t5.be0", mem_be, 4'b1000);
        check("t5.wd0", mem_wd, 32'hEF000000);
        finish_req("t5", 2, 1'b0, 32'h0);
        check("t5.a1", g_a2, 32'h0);
        check("t5.be1", g_be2, 4'b0001);
        check("t5.wd1", g_wd2, 32'h000000BE);
        check("t5.w15", tb_mem[15], 32'hEF000000);
        check("t5.w0", tb_mem[0], 32'h000000BE);

        // Illegal encodings
        drive(1'b0, 3'b011, 32'h4, 32'h0);
        check("t6.ill0", {mem_we, mem_be}, 5'b0);
        finish_req("t6.ill0", 1, 1'b1, 32'h0);
        drive(1'b1, 3'b100, 32'h8, 32'h12345678);
        check("t6.ill1", {mem_we, mem_be}, 5'b0);
        finish_req("t6.ill1", 1, 1'b1, 32'h0);

        // Back-to-back aligned LWs
        bexp[0] = 32'hA1A2A3A4;
        bexp[1] = 32'hB1B2B3B4;
        bexp[2] = 32'hC1C2C3C4;
        set_word(1, bexp[0]);
        set_word(2, bexp[1]);
        set_word(3, bexp[2]);
        @(negedge clk);
        req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h4;
        #1;
        check("b2b.rdy", req_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k < 2) addr = 32'h8 + 32'(4 * k);
            else       req_valid = 1'b0;
            #1;
            check("b2b.rv", resp_valid, 1'b1);
            check("b2b.ld", load_data, bexp[k]);
            check("b2b.rdy", req_ready, 1'b1);
        end
        @(negedge clk);
        #1;
        check("b2b.end", resp_valid, 1'b0);

        // Randomized accesses against the byte model
        for (int w = 0; w < 16; w++) set_word(w, $urandom);
        for (int t = 0; t < 300; t++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = {($urandom_range(0, 3) == 0) ? 26'h3FFFFFF : 26'h0, 6'($urandom_range(0, 63))};
            d  = $urandom;
            model(st, f3, a, d, lat, err, ld);
            drive(st, f3, a, d);
            finish_req("rnd", lat, err, ld);
        end
        for (int w = 0; w < 16; w++)
            check("rnd.mem", tb_mem[w], {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator between the core's memory stage and the byte-enabled, word-addressed data memory.
- Generates word addresses, byte enables and lane-aligned write data for stores.
- Extracts and sign- or zero-extends load data.
- Splits accesses that cross a word boundary into two sequential word accesses, with a ready/valid handshake toward the pipeline.

Parameters:
XLEN, 32, data/address width; only 32 supported.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  pipeline presents an access
req_ready  out  1  block can accept; high only in IDLE
is_store  in  1  1 = store, 0 = load
funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  32  byte address
store_data  in  32  store value, right-justified
resp_valid  out  1  one-cycle pulse: access complete
resp_err  out  1  qualifies resp_valid: illegal funct3
load_data  out  32  extended load result; 0 for stores and errors
mem_we  out  1  memory write enable
mem_be  out  4  memory byte enables
mem_a  out  32  memory address, always word-aligned ([1:0]=00)
mem_wd  out  32  memory write data, byte lanes aligned
mem_rd  in  32  memory read data; combinational, same cycle as mem_a

Behaviour:
- States: IDLE, SECOND. Reset (async, any time) forces IDLE and clears resp_valid, resp_err, load_data and internal buffers. Combinational mem outputs then read 0.
- Reset mid-split abandons the second access. Bytes already written in the first word remain written.
- Accept: req_valid && req_ready on a rising edge.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is illegal.
- Illegal request:
  - mem_we=0 and mem_be=0 during the accept cycle.
  - Next cycle: resp_valid=1, resp_err=1, load_data=0.
- Size and masks:
  - size = funct3[1:0]; base mask = 0001, 0011 or 1111.
  - off = addr[1:0]; m8 = base << off, an 8-bit value.
  - cross = (m8[7:4] != 0).
- Store data: sd64 = zero-extended store_data << (8*off), 64 bits.
- First access (IDLE, accepting):
  - mem_a = {addr[31:2], 00}, mem_be = m8[3:0].
  - mem_wd = sd64[31:0], mem_we = is_store.
- Load capture: mem_rd is latched into buf0 at the accept edge.
- Outputs when not accepting: mem_we=0, mem_be=0, mem_a=0, mem_wd=0.
- Non-crossing access:
  - Stays in IDLE.
  - resp_valid pulses the next cycle (latency 1).
  - Back-to-back accepts every cycle are allowed.
- Crossing access:
  - Go to SECOND with req_ready=0.
  - In SECOND: mem_a = first word address + 4 (32-bit wrap; 0xFFFFFFFC+4 = 0x00000000), mem_be = m8[7:4], mem_wd = sd64[63:32], mem_we = stored is_store.
  - The load captures mem_rd as buf1.
  - Return to IDLE; resp_valid pulses the next cycle (latency 2).
  - A new request cannot be accepted during SECOND.
- Load result:
  - raw = ({buf1, buf0} >> 8*off)[31:0], with buf1=0 when not crossing.
  - B: sign-extend raw[7:0]. H: sign-extend raw[15:0].
  - BU/HU: zero-extend. W: raw.
  - load_data is registered and valid with resp_valid.
  - load_data holds its value until the next response and reads 0 for stores.
- req_valid deasserted: no memory activity; state unchanged.
- resp_valid never asserts in two consecutive cycles for one request.
- resp_err is 0 whenever resp_valid is 0.

Test Plan:
1. Reset asserted mid-SECOND (misaligned SW in flight) → immediate IDLE. req_ready=1, resp_valid=0, mem_be=0. No second write occurs. The first word shows only the bytes written before reset.
2. SB store_data=0x000000A5 to addr 0x00000006 → same cycle mem_a=0x4, mem_be=0100, mem_wd=0x00A50000, mem_we=1. Next cycle resp_valid=1, resp_err=0, load_data=0.
3. Memory word0=0x8899AABB. LB from 0x1 → load_data=0xFFFFFFAA after 1 cycle. LBU from 0x1 → 0x000000AA. LH from 0x2 → 0xFFFF8899.
4. Memory word0 (addr 0x0)=0x44332211, word1 (addr 0x4)=0x88776655. LW from 0x3:
   - cycle N: mem_a=0x0, mem_be=1000.
   - cycle N+1: mem_a=0x4, mem_be=0111, req_ready=0.
   - cycle N+2: resp_valid=1, load_data=0x77665544.
5. SH store_data=0x0000BEEF to addr 0xFFFFFFFF:
   - first access: mem_a=0xFFFFFFFC, mem_be=1000, mem_wd=0xEF000000.
   - second access: mem_a=0x00000000, mem_be=0001, mem_wd=0x000000BE.
6. funct3=011 load, then funct3=100 store, then three back-to-back aligned LWs:
   - each illegal request: mem_be=0, mem_we=0, then resp_err=1, load_data=0.
   - aligned LWs: accepted on consecutive cycles, resp_valid high for 3 consecutive cycles with the correct data.
